ext_interrupt_requester: RTL and testbench

EXT_INTERRUPT_REQUESTER -- requirements
Module: ext_interrupt_requester

---
 rtl/ext_interrupt_requester.sv | 130 +++++++++++++
 tb/tb_ext_interrupt_requester.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ext_interrupt_requester.sv
// ============================================================================
// Module   : ext_interrupt_requester
// Purpose  : Captures rising edges on device interrupt lines into pending
//            bits and presents the lowest pending line to the core.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ext_interrupt_requester #(
    parameter int P_LINES = 32
) (
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic [P_LINES-1:0] iIRQ_LINE,
    input  logic               iCONF_VALID,
    input  logic [5:0]         iCONF_ENTRY,
    input  logic               iCONF_ENABLE,
    input  logic               iFLUSH,
    output logic               oEXT_ACTIVE,
    output logic [5:0]         oEXT_NUM,
    input  logic               iEXT_ACK,
    output logic [P_LINES-1:0] oPENDING
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;

    logic [1:0]         state_q,   state_d;
    logic               active_q,  active_d;
    logic [5:0]         num_q,     num_d;
    logic [P_LINES-1:0] pending_q, pending_d;
    logic [P_LINES-1:0] enable_q,  enable_d;
    logic [P_LINES-1:0] prev_q,    prev_d;

    logic [P_LINES-1:0] w_rise;
    logic [5:0]         w_lowest;
    logic               w_in_req;

    assign w_rise   = iIRQ_LINE & ~prev_q & enable_q;
    assign w_in_req = (state_q == S_REQ);

    always_comb begin
        w_lowest = 6'd0;
        for (int i = P_LINES - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                w_lowest = 6'(i);
            end
        end
    end

    always_comb begin
        prev_d   = iIRQ_LINE;
        enable_d = enable_q;
        if (iCONF_VALID) begin
            for (int i = 0; i < P_LINES; i++) begin
                if (iCONF_ENTRY == 6'(i)) begin
                    enable_d[i] = iCONF_ENABLE;
                end
            end
        end
    end

    // Acknowledge clears first so a same-cycle new edge on that line survives.
    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < P_LINES; i++) begin
            if (w_in_req && iEXT_ACK && (num_q == 6'(i))) begin
                pending_d[i] = 1'b0;
            end
            if (iFLUSH && !(w_in_req && (num_q == 6'(i)))) begin
                pending_d[i] = 1'b0;
            end
        end
        if (!iFLUSH) begin
            pending_d = pending_d | w_rise;
        end
    end

    always_comb begin
        state_d  = state_q;
        active_d = active_q;
        num_d    = num_q;
        case (state_q)
            S_IDLE: begin
                active_d = 1'b0;
                if (|pending_q) begin
                    num_d    = w_lowest;
                    active_d = 1'b1;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                active_d = 1'b1;
                if (iEXT_ACK) begin
                    active_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                active_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q   <= S_IDLE;
            active_q  <= 1'b0;
            num_q     <= 6'd0;
            pending_q <= '0;
            enable_q  <= '0;
            prev_q    <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            num_q     <= num_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            prev_q    <= prev_d;
        end
    end

    assign oEXT_ACTIVE = active_q;
    assign oEXT_NUM    = num_q;
    assign oPENDING    = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_ext_interrupt_requester.sv
// ============================================================================
// Module   : tb_ext_interrupt_requester
// Purpose  : Directed self-checking bench for ext_interrupt_requester.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ext_interrupt_requester;

    localparam int P_LINES = 32;

    logic               clk;
    logic               rst_n;
    logic [P_LINES-1:0] irq_line;
    logic               conf_valid;
    logic [5:0]         conf_entry;
    logic               conf_enable;
    logic               flush;
    logic               ext_active;
    logic [5:0]         ext_num;
    logic               ext_ack;
    logic [P_LINES-1:0] pending;

    int n_checks = 0;
    int n_fail   = 0;

    ext_interrupt_requester #(.P_LINES(P_LINES)) u_dut (
        .iCLOCK      (clk),
        .inRESET     (rst_n),
        .iIRQ_LINE   (irq_line),
        .iCONF_VALID (conf_valid),
        .iCONF_ENTRY (conf_entry),
        .iCONF_ENABLE(conf_enable),
        .iFLUSH      (flush),
        .oEXT_ACTIVE (ext_active),
        .oEXT_NUM    (ext_num),
        .iEXT_ACK    (ext_ack),
        .oPENDING    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic conf(input int entry, input logic en);
        conf_valid  = 1'b1;
        conf_entry  = 6'(entry);
        conf_enable = en;
        cycle();
        conf_valid  = 1'b0;
    endtask

    task automatic ack_once();
        ext_ack = 1'b1;
        cycle();
        ext_ack = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        irq_line    = '0;
        conf_valid  = 1'b0;
        conf_entry  = 6'd0;
        conf_enable = 1'b0;
        flush       = 1'b0;
        ext_ack     = 1'b0;
        #23;
        check_val("rst_active",  64'(ext_active), 64'd0);
        check_val("rst_num",     64'(ext_num),    64'd0);
        check_val("rst_pending", 64'(pending),    64'd0);
        rst_n = 1'b1;
        cycle();

        // Single pulse on line 5
        conf(5, 1'b1);
        irq_line[5] = 1'b1;
        cycle();
        irq_line = '0;
        check_val("l5_pend_k",   64'(pending),    64'h20);
        check_val("l5_act_k",    64'(ext_active), 64'd0);
        cycle();
        check_val("l5_act_k1",   64'(ext_active), 64'd1);
        check_val("l5_num_k1",   64'(ext_num),    64'd5);
        cycle(); cycle(); cycle();
        check_val("l5_hold_act", 64'(ext_active), 64'd1);
        check_val("l5_hold_num", 64'(ext_num),    64'd5);
        ack_once();
        check_val("l5_ack_act",  64'(ext_active), 64'd0);
        check_val("l5_ack_pend", 64'(pending),    64'd0);
        check_val("l5_ack_num",  64'(ext_num),    64'd5);
        cycle();
        check_val("l5_idle_act", 64'(ext_active), 64'd0);

        // Lines 3 and 9 together: priority, one idle gap
        conf(3, 1'b1);
        conf(9, 1'b1);
        irq_line = 32'h0000_0208;
        cycle();
        irq_line = '0;
        check_val("p39_pend",    64'(pending),    64'h208);
        cycle();
        check_val("p39_num3",    64'(ext_num),    64'd3);
        check_val("p39_act3",    64'(ext_active), 64'd1);
        ack_once();
        check_val("p39_gap_act", 64'(ext_active), 64'd0);
        check_val("p39_gap_pnd", 64'(pending),    64'h200);
        cycle();
        check_val("p39_act9",    64'(ext_active), 64'd1);
        check_val("p39_num9",    64'(ext_num),    64'd9);
        ack_once();
        check_val("p39_end_act", 64'(ext_active), 64'd0);
        check_val("p39_end_pnd", 64'(pending),    64'd0);

        // Disabled line 7: edge discarded, later enable does not revive it
        irq_line[7] = 1'b1;
        cycle();
        irq_line = '0;
        check_val("l7_pend",     64'(pending),    64'd0);
        conf(7, 1'b1);
        cycle(); cycle();
        check_val("l7_act",      64'(ext_active), 64'd0);
        check_val("l7_pend2",    64'(pending),    64'd0);

        // New edge on line 4 during its own ACK cycle wins
        conf(4, 1'b1);
        irq_line[4] = 1'b1;
        cycle();
        irq_line = '0;
        cycle();
        check_val("l4_num",      64'(ext_num),    64'd4);
        ext_ack     = 1'b1;
        irq_line[4] = 1'b1;
        cycle();
        ext_ack  = 1'b0;
        irq_line = '0;
        check_val("l4_ack_act",  64'(ext_active), 64'd0);
        check_val("l4_ack_pend", 64'(pending),    64'h10);
        cycle();
        check_val("l4_re_act",   64'(ext_active), 64'd1);
        check_val("l4_re_num",   64'(ext_num),    64'd4);
        ack_once();
        check_val("l4_end_pend", 64'(pending),    64'd0);

        // Flush with 2 in flight and 6 pending; disabling 2 keeps the request
        conf(2, 1'b1);
        conf(6, 1'b1);
        irq_line[2] = 1'b1;
        cycle();
        irq_line = '0;
        cycle();
        check_val("fl_num2",     64'(ext_num),    64'd2);
        irq_line[6] = 1'b1;
        cycle();
        irq_line = '0;
        check_val("fl_pend26",   64'(pending),    64'h44);
        conf(2, 1'b0);
        check_val("fl_dis_act",  64'(ext_active), 64'd1);
        flush       = 1'b1;
        irq_line[6] = 1'b1;
        cycle();
        flush    = 1'b0;
        irq_line = '0;
        check_val("fl_pend",     64'(pending),    64'h04);
        check_val("fl_act",      64'(ext_active), 64'd1);
        cycle(); cycle();
        check_val("fl_hold_num", 64'(ext_num),    64'd2);
        ack_once();
        check_val("fl_ack_pend", 64'(pending),    64'd0);
        cycle(); cycle();
        check_val("fl_no_req",   64'(ext_active), 64'd0);

        // ACK sampled in IDLE is ignored
        irq_line[5] = 1'b1;
        cycle();
        irq_line = '0;
        ext_ack  = 1'b1;
        cycle();
        ext_ack  = 1'b0;
        check_val("idack_act",   64'(ext_active), 64'd1);
        check_val("idack_num",   64'(ext_num),    64'd5);
        check_val("idack_pend",  64'(pending),    64'h20);

        // Reset mid-request, line held high across release
        irq_line[5] = 1'b1;
        #2;
        rst_n = 1'b0;
        #2;
        check_val("mrst_act",    64'(ext_active), 64'd0);
        check_val("mrst_pend",   64'(pending),    64'd0);
        rst_n = 1'b1;
        cycle(); cycle(); cycle();
        check_val("post_act",    64'(ext_active), 64'd0);
        check_val("post_pend",   64'(pending),    64'd0);
        conf(5, 1'b1);
        cycle(); cycle();
        check_val("post_en_act", 64'(ext_active), 64'd0);
        check_val("post_en_pnd", 64'(pending),    64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
